// File: rtl/ula_multiciclo_if.sv
// Operand/command and result bus of the multi-cycle ALU.
// The master drives the operands and the start request; the slave (the ALU) returns the results.
interface ula_multiciclo_if #(
    parameter int unsigned WIDTH = 8
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       opcode;
    logic             inicio;
    logic             ocupado;
    logic             pronto;
    logic [WIDTH-1:0] saidaULA;
    logic             zero;
    logic             carry;
    logic             divzero;

    modport master (
        output a, b, opcode, inicio,
        input  ocupado, pronto, saidaULA, zero, carry, divzero
    );

    modport slave (
        input  a, b, opcode, inicio,
        output ocupado, pronto, saidaULA, zero, carry, divzero
    );
endinterface

// File: rtl/ula_multiciclo.sv
// Multi-cycle ALU. Single-cycle logic/add/sub ops; shift-add multiply and restoring
// divide/remainder resolve one bit per cycle over WIDTH cycles.
module ula_multiciclo #(
    parameter int unsigned WIDTH = 8
) (
    input logic            clock,
    input logic            reset,
    ula_multiciclo_if.slave bus
);
    localparam int unsigned CntW = $clog2(WIDTH);
    localparam logic [3:0] OpAdd = 4'b0001;
    localparam logic [3:0] OpSub = 4'b0010;
    localparam logic [3:0] OpMul = 4'b0011;
    localparam logic [3:0] OpDiv = 4'b0100;
    localparam logic [3:0] OpRem = 4'b1100;

    typedef enum logic [1:0] {StOcioso, StCalc, StFim} state_e;

    state_e             state_q, state_d;
    logic [3:0]         op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic               zero_q, zero_d, carry_q, carry_d, divzero_q, divzero_d;

    logic [WIDTH:0]     add_sum, mul_sum, div_shift;
    logic [WIDTH-1:0]   div_diff, one_res;
    logic               div_ge, one_carry;
    logic [2*WIDTH-1:0] step;

    // One iteration: acc holds {partial product high, multiplier} for mul and
    // {remainder, dividend/quotient} for div/rem.
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : '0);
        div_shift = acc_q[2*WIDTH-1:WIDTH-1];
        div_ge    = div_shift >= {1'b0, b_q};
        div_diff  = div_shift[WIDTH-1:0] - b_q;
        if (op_q == OpMul) begin
            step = {mul_sum, acc_q[WIDTH-1:1]};
        end else begin
            step = {(div_ge ? div_diff : div_shift[WIDTH-1:0]), acc_q[WIDTH-2:0], div_ge};
        end
    end

    always_comb begin
        add_sum   = {1'b0, bus.a} + {1'b0, bus.b};
        one_carry = 1'b0;
        case (bus.opcode)
            OpAdd: begin
                one_res   = add_sum[WIDTH-1:0];
                one_carry = add_sum[WIDTH];
            end
            OpSub: begin
                one_res   = bus.a - bus.b;
                one_carry = bus.a < bus.b;
            end
            4'b0101: one_res = bus.a & bus.b;
            4'b0110: one_res = bus.a | bus.b;
            4'b0111: one_res = ~bus.a;
            4'b1000: one_res = bus.a ^ bus.b;
            4'b1001: one_res = bus.a ~^ bus.b;
            4'b1010: one_res = bus.a;
            4'b1011: one_res = ~bus.a;
            default: one_res = '0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        res_d     = res_q;
        zero_d    = zero_q;
        carry_d   = carry_q;
        divzero_d = divzero_q;
        unique case (state_q)
            StOcioso: begin
                if (bus.inicio) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    op_d    = bus.opcode;
                    cnt_d   = '0;
                    if (bus.opcode == OpMul) begin
                        acc_d   = {{WIDTH{1'b0}}, bus.b};
                        state_d = StCalc;
                    end else if (bus.opcode == OpDiv || bus.opcode == OpRem) begin
                        if (bus.b == '0) begin
                            res_d     = (bus.opcode == OpDiv) ? '1 : bus.a;
                            zero_d    = (bus.opcode == OpRem) && (bus.a == '0);
                            carry_d   = 1'b0;
                            divzero_d = 1'b1;
                            state_d   = StFim;
                        end else begin
                            acc_d   = {{WIDTH{1'b0}}, bus.a};
                            state_d = StCalc;
                        end
                    end else begin
                        res_d     = one_res;
                        zero_d    = one_res == '0;
                        carry_d   = one_carry;
                        divzero_d = 1'b0;
                        state_d   = StFim;
                    end
                end
            end
            StCalc: begin
                acc_d = step;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CntW'(WIDTH - 1)) begin
                    cnt_d     = '0;
                    state_d   = StFim;
                    divzero_d = 1'b0;
                    if (op_q == OpMul) begin
                        res_d   = step[WIDTH-1:0];
                        carry_d = |step[2*WIDTH-1:WIDTH];
                    end else begin
                        res_d   = (op_q == OpRem) ? step[2*WIDTH-1:WIDTH] : step[WIDTH-1:0];
                        carry_d = 1'b0;
                    end
                    zero_d = ((op_q == OpRem) ? step[2*WIDTH-1:WIDTH] : step[WIDTH-1:0]) == '0;
                end
            end
            StFim: state_d = StOcioso;
            default: state_d = StOcioso;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= StOcioso;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            res_q     <= '0;
            zero_q    <= 1'b0;
            carry_q   <= 1'b0;
            divzero_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            res_q     <= res_d;
            zero_q    <= zero_d;
            carry_q   <= carry_d;
            divzero_q <= divzero_d;
        end
    end

    assign bus.ocupado  = state_q != StOcioso;
    assign bus.pronto   = state_q == StFim;
    assign bus.saidaULA = res_q;
    assign bus.zero     = zero_q;
    assign bus.carry    = carry_q;
    assign bus.divzero  = divzero_q;
endmodule

// File: doc/ula_multiciclo.md
ULA_MULTICICLO -- requirements
Module: ula_multiciclo

Interface
REQ-001 Parameter WIDTH, default 8: operand and result width in bits; legal range 4..32.
REQ-002 clock  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high; forces the reset state immediately, regardless of clock.
REQ-004 a  input  WIDTH  operand A, unsigned.
REQ-005 b  input  WIDTH  operand B, unsigned.
REQ-006 opcode  input  4  operation select (REQ-012).
REQ-007 inicio  input  1  start request; sampled only while ocupado=0.
REQ-008 ocupado  output  1  high while an operation is in progress or completing.
REQ-009 pronto  output  1  one-cycle pulse marking a new result on saidaULA and the flags.
REQ-010 saidaULA  output  WIDTH  registered result; held until the next completion.
REQ-011 zero, carry, divzero  output  1 each  registered flags, updated only together with saidaULA.

Function
REQ-012 Opcode map:
- 0000: 0
- 0001: a+b
- 0010: a-b
- 0011: a*b (low WIDTH bits)
- 0100: a/b (quotient)
- 0101: a&b
- 0110: a|b
- 0111: ~a
- 1000: a^b
- 1001: a~^b
- 1010: a
- 1011: ~a
- 1100: a%b (remainder)
- 1101-1111: 0
REQ-013 FSM states are OCIOSO, CALC and FIM; ocupado SHALL be 1 exactly when the state is not OCIOSO.
REQ-014 In OCIOSO, a rising edge with inicio=1 SHALL latch a, b and opcode internally; later changes to these inputs SHALL not affect the operation in progress.
REQ-015 Single-cycle opcodes (all except 0011, 0100, 1100) SHALL compute on the start edge, load saidaULA and the flags, and go to FIM.
REQ-016 Opcode 0011 SHALL use iterative shift-add, one partial product per cycle: CALC for exactly WIDTH edges, then FIM.
REQ-017 Opcodes 0100 and 1100 SHALL use restoring division, one quotient bit per cycle: CALC for exactly WIDTH edges, then FIM.
REQ-018 pronto SHALL be 1 only while in FIM (exactly one cycle); FIM SHALL always return to OCIOSO on the next edge.
REQ-019 Latency from the start edge to pronto high: 1 cycle for single-cycle ops; WIDTH+1 cycles for mul/div/rem.
REQ-020 inicio while ocupado=1 SHALL be ignored; a new start is accepted only on an edge where the state is OCIOSO.
REQ-021 zero SHALL be 1 iff the new saidaULA equals 0.
REQ-022 carry SHALL be set per operation:
- add: carry-out of bit WIDTH-1.
- sub: borrow (a<b).
- mul: 1 iff the high WIDTH bits of the full 2*WIDTH product are nonzero.
- all other ops: 0.
REQ-023 divzero SHALL be 1 only for opcode 0100 or 1100 with b=0, and 0 for all other completions.
REQ-024 Division by zero SHALL skip CALC and go directly to FIM on the start edge (latency 1).
- Opcode 0100 result: all ones.
- Opcode 1100 result: a.
REQ-025 Arithmetic SHALL be unsigned modulo 2^WIDTH; the internal multiply accumulator SHALL be 2*WIDTH bits wide.

Reset
REQ-026 While reset=1, all of the following SHALL be 0 and the state SHALL be OCIOSO: saidaULA, zero, carry, divzero, pronto, ocupado, the iteration counter and the internal accumulators.
REQ-027 Reset asserted mid-CALC SHALL abort the operation without producing a pronto pulse.
REQ-028 After reset deasserts, the first edge with inicio=1 SHALL start a new operation normally.

Verification (WIDTH=8)
REQ-029 Add: a=200, b=100, opcode=0001, inicio pulse -> pronto 1 cycle later; saidaULA=44, carry=1, zero=0.
REQ-030 Sub: a=5, b=7, opcode=0010 -> saidaULA=254, carry=1. Xor: a=0xAA, b=0xAA, opcode=1000 -> saidaULA=0, zero=1.
REQ-031 Multiply:
- a=15, b=17, opcode=0011 -> ocupado high 9 cycles, pronto at cycle 9, saidaULA=255, carry=0.
- a=16, b=16 -> saidaULA=0, zero=1, carry=1.
REQ-032 Divide:
- a=100, b=7, opcode=0100 -> saidaULA=14 at cycle 9.
- Same operands, opcode=1100 -> saidaULA=2.
- a=9, b=0, opcode=0100 -> pronto at cycle 1, saidaULA=255, divzero=1.
REQ-033 Busy and reset:
- inicio held high during a multiply, with a and b changed mid-CALC -> the result uses the latched operands, and no second operation starts until after FIM.
- reset asserted at cycle 4 of a divide -> all outputs 0 immediately, no pronto.
